// File: rtl/atomic_cnt_pkg.sv
// Shared types and width helpers for the atomic counter bank.
// Optional overflow flags are enabled with `define ATOMIC_CNT_OVF_EN.
package atomic_cnt_pkg;

    typedef enum logic {IDLE, BURST} state_t;

    function automatic int beats(input int count_w, input int data_w);
        return count_w / data_w;
    endfunction

    function automatic bit width_ok(input int count_w, input int data_w);
        return (data_w > 0) && (count_w >= data_w) && ((count_w % data_w) == 0);
    endfunction

endpackage

// File: rtl/atomic_counter_bank_if.sv
// Read bus of the atomic counter bank: request side plus registered response.
interface atomic_counter_bank_if #(
    parameter int NUM_CNT = 4,
    parameter int DATA_W  = 32
);
    localparam int SEL_W = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;

    logic              req_i;
    logic              atomic_i;
    logic [SEL_W-1:0]  sel_i;
    logic              clr_i;
    logic              ack_o;
    logic [DATA_W-1:0] count_o;
    logic              err_o;

    modport master (output req_i, atomic_i, sel_i, clr_i, input ack_o, count_o, err_o);
    modport slave  (input req_i, atomic_i, sel_i, clr_i, output ack_o, count_o, err_o);

endinterface

// File: rtl/atomic_cnt_lane.sv
// One event counter: increment by 1 or FAST_INC, wrap or saturate, clear on read.
// Sticky overflow flag present only with `define ATOMIC_CNT_OVF_EN.
module atomic_cnt_lane #(
    parameter int          COUNT_W  = 64,
    parameter logic [63:0] FAST_INC = 64'd1000000,
    parameter bit          SAT_MODE = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               trig,
    input  logic               fast,
    input  logic               clr,
    output logic [COUNT_W-1:0] cnt_nxt
`ifdef ATOMIC_CNT_OVF_EN
    ,
    output logic               ovf
`endif
);

    logic [COUNT_W-1:0] cnt;
    logic [COUNT_W-1:0] inc;
    logic [COUNT_W:0]   sum;
    logic               carry;

    always_comb begin
        inc = '0;
        if (trig) inc = fast ? COUNT_W'(FAST_INC) : COUNT_W'(1);
        sum     = {1'b0, cnt} + {1'b0, inc};
        carry   = sum[COUNT_W];
        cnt_nxt = (SAT_MODE && carry) ? '1 : sum[COUNT_W-1:0];
    end

    // cnt_nxt feeds the snapshot, so a clearing read still captures this cycle's increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt <= '0;
        else       cnt <= clr ? '0 : cnt_nxt;
    end

`ifdef ATOMIC_CNT_OVF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)    ovf <= 1'b0;
        else if (clr) ovf <= 1'b0;
        else if (carry) ovf <= 1'b1;
    end
`endif

endmodule

// File: rtl/atomic_counter_bank.sv
// Bank of free-running counters read as tear-free multi-beat snapshots.
// `define ATOMIC_CNT_OVF_EN adds sticky per-counter overflow flags (ovf_o).
module atomic_counter_bank
    import atomic_cnt_pkg::*;
#(
    parameter int          NUM_CNT  = 4,
    parameter int          DATA_W   = 32,
    parameter int          COUNT_W  = 64,
    parameter logic [63:0] FAST_INC = 64'd1000000,
    parameter bit          SAT_MODE = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CNT-1:0]   trig_i,
    input  logic                 fast_i,
    atomic_counter_bank_if.slave bus
`ifdef ATOMIC_CNT_OVF_EN
    ,
    output logic [NUM_CNT-1:0]   ovf_o
`endif
);

    localparam int SEL_W = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;
    localparam int BEATS = beats(COUNT_W, DATA_W);
    localparam int PTR_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (!width_ok(COUNT_W, DATA_W)) begin : g_bad_width
        $error("atomic_counter_bank: COUNT_W must be a multiple of DATA_W");
    end

    logic [NUM_CNT-1:0][COUNT_W-1:0] cnt_nxt;
    logic [NUM_CNT-1:0]              clr_vec;
    logic [NUM_CNT-1:0]              sel_hot;
    logic [COUNT_W-1:0]              sel_nxt;
    logic                            sel_ok;
    logic                            start_ok;
    logic                            ovf_hit;

    state_t                          state;
    logic [PTR_W-1:0]                ptr;
    logic [BEATS-1:0][DATA_W-1:0]    snap;
    logic                            ack_q;
    logic [DATA_W-1:0]               count_q;
    logic                            err_q;

    if ((1 << SEL_W) == NUM_CNT) begin : g_sel_full
        assign sel_ok = 1'b1;
    end else begin : g_sel_range
        assign sel_ok = (int'(bus.sel_i) < NUM_CNT);
    end

    always_comb begin
        sel_nxt = '0;
        sel_hot = '0;
        for (int k = 0; k < NUM_CNT; k++) begin
            if (bus.sel_i == SEL_W'(k)) begin
                sel_nxt    = cnt_nxt[k];
                sel_hot[k] = 1'b1;
            end
        end
    end

    assign start_ok = bus.req_i && !bus.atomic_i && sel_ok;
    assign clr_vec  = (start_ok && bus.clr_i) ? sel_hot : '0;

`ifdef ATOMIC_CNT_OVF_EN
    assign ovf_hit = |(ovf_o & sel_hot);
`else
    assign ovf_hit = 1'b0;
`endif

    for (genvar k = 0; k < NUM_CNT; k++) begin : g_lane
        atomic_cnt_lane #(
            .COUNT_W  (COUNT_W),
            .FAST_INC (FAST_INC),
            .SAT_MODE (SAT_MODE)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .trig    (trig_i[k]),
            .fast    (fast_i),
            .clr     (clr_vec[k]),
            .cnt_nxt (cnt_nxt[k])
`ifdef ATOMIC_CNT_OVF_EN
            ,
            .ovf     (ovf_o[k])
`endif
        );
    end

    // Response defaults to idle every cycle; a start wins over any burst in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            snap    <= '0;
            ack_q   <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            ack_q   <= bus.req_i;
            count_q <= '0;
            err_q   <= 1'b0;
            if (bus.req_i && !bus.atomic_i) begin
                if (sel_ok) begin
                    snap    <= sel_nxt;
                    count_q <= sel_nxt[DATA_W-1:0];
                    ptr     <= PTR_W'(1);
                    state   <= (BEATS > 1) ? BURST : IDLE;
                    err_q   <= ovf_hit;
                end else begin
                    err_q   <= 1'b1;
                end
            end else if (bus.req_i) begin
                if (state == BURST) begin
                    count_q <= snap[ptr];
                    ptr     <= ptr + PTR_W'(1);
                    if (ptr == PTR_W'(BEATS - 1)) state <= IDLE;
                end else begin
                    err_q   <= 1'b1;
                end
            end
        end
    end

    assign bus.ack_o   = ack_q;
    assign bus.count_o = count_q;
    assign bus.err_o   = err_q;

endmodule

// File: tb/tb_atomic_counter_bank.sv
// Directed bench for atomic_counter_bank: default 64/32 bank plus 32-bit wrap and saturate banks.
module tb_atomic_counter_bank;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] trig = 4'hF;
    logic       fast = 1'b0;
    logic [1:0] trig_s = 2'b00;
    logic       fast_s = 1'b0;
    int         checks = 0;
    int         errors = 0;

`ifdef ATOMIC_CNT_OVF_EN
    localparam bit OVF = 1'b1;
    logic [3:0] ovf_m;
    logic [1:0] ovf_w, ovf_s;
`else
    localparam bit OVF = 1'b0;
`endif

    always #5 clk = ~clk;

    atomic_counter_bank_if #(.NUM_CNT(4), .DATA_W(32)) bus ();
    atomic_counter_bank_if #(.NUM_CNT(2), .DATA_W(32)) bw ();
    atomic_counter_bank_if #(.NUM_CNT(2), .DATA_W(32)) bs ();

    atomic_counter_bank #(.NUM_CNT(4), .DATA_W(32), .COUNT_W(64)) dut (
        .clk(clk), .reset(reset), .trig_i(trig), .fast_i(fast), .bus(bus)
`ifdef ATOMIC_CNT_OVF_EN
        , .ovf_o(ovf_m)
`endif
    );

    atomic_counter_bank #(.NUM_CNT(2), .DATA_W(32), .COUNT_W(32),
                          .FAST_INC(64'hFFFF_FFFF), .SAT_MODE(1'b0)) dut_wrap (
        .clk(clk), .reset(reset), .trig_i(trig_s), .fast_i(fast_s), .bus(bw)
`ifdef ATOMIC_CNT_OVF_EN
        , .ovf_o(ovf_w)
`endif
    );

    atomic_counter_bank #(.NUM_CNT(2), .DATA_W(32), .COUNT_W(32),
                          .FAST_INC(64'hFFFF_FFFF), .SAT_MODE(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .trig_i(trig_s), .fast_i(fast_s), .bus(bs)
`ifdef ATOMIC_CNT_OVF_EN
        , .ovf_o(ovf_s)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic req, input logic atomic, input logic [1:0] sel, input logic clr);
        bus.req_i = req; bus.atomic_i = atomic; bus.sel_i = sel; bus.clr_i = clr;
    endtask

    task automatic drv_s(input logic req, input logic clr);
        bw.req_i = req; bw.atomic_i = 1'b0; bw.sel_i = 1'b0; bw.clr_i = clr;
        bs.req_i = req; bs.atomic_i = 1'b0; bs.sel_i = 1'b0; bs.clr_i = clr;
    endtask

    initial begin
        drv(1'b0, 1'b0, 2'd0, 1'b0);
        drv_s(1'b0, 1'b0);

        // reset held with all triggers active
        step(); step();
        chk("rst_ack", 64'(bus.ack_o), 64'd0);
        chk("rst_cnt", 64'(bus.count_o), 64'd0);
        chk("rst_err", 64'(bus.err_o), 64'd0);
        reset = 1'b0;
        trig  = 4'b0001;
        repeat (10) step();
        drv(1'b1, 1'b0, 2'd0, 1'b0);
        step();
        chk("t1_ack", 64'(bus.ack_o), 64'd1);
        chk("t1_lsb", 64'(bus.count_o), 64'd11);
        chk("t1_err", 64'(bus.err_o), 64'd0);
        drv(1'b1, 1'b1, 2'd0, 1'b0);
        step();
        chk("t1_msb", 64'(bus.count_o), 64'd0);
        drv(1'b0, 1'b0, 2'd0, 1'b0);
        trig = 4'b0000;
        step();
        chk("idle_ack", 64'(bus.ack_o), 64'd0);
        chk("idle_cnt", 64'(bus.count_o), 64'd0);

        // 32-bit banks: FAST_INC preloads all-ones, then two single increments
        trig_s = 2'b01; fast_s = 1'b1;
        step();
        fast_s = 1'b0;
        step(); step();
        trig_s = 2'b00;
`ifdef ATOMIC_CNT_OVF_EN
        chk("t5_ovf_w", 64'(ovf_w), 64'd1);
        chk("t5_ovf_s", 64'(ovf_s), 64'd1);
`endif
        drv_s(1'b1, 1'b0);
        step();
        chk("t5_wrap", 64'(bw.count_o), 64'd1);
        chk("t5_sat", 64'(bs.count_o), 64'hFFFF_FFFF);
        chk("t5_err_w", 64'(bw.err_o), 64'(OVF));
        drv_s(1'b1, 1'b1);
        step();
        chk("t5_sat_clr", 64'(bs.count_o), 64'hFFFF_FFFF);
        drv_s(1'b1, 1'b0);
        step();
        chk("t5_sat_after", 64'(bs.count_o), 64'd0);
        chk("t5_err_s", 64'(bs.err_o), 64'd0);
`ifdef ATOMIC_CNT_OVF_EN
        chk("t5_ovf_s_clr", 64'(ovf_s), 64'd0);
`endif
        drv_s(1'b0, 1'b0);

        // 5000 fast cycles on ch2: 5e9 = 0x1_2A05_F200, counting continues during the burst
        trig = 4'b0100; fast = 1'b1;
        repeat (4999) step();
        drv(1'b1, 1'b0, 2'd2, 1'b0);
        step();
        chk("t2_lsb", 64'(bus.count_o), 64'h2A05_F200);
        drv(1'b0, 1'b0, 2'd0, 1'b0);
        repeat (3) step();
        drv(1'b1, 1'b1, 2'd0, 1'b0);
        step();
        chk("t2_msb", 64'(bus.count_o), 64'd1);
        drv(1'b0, 1'b0, 2'd0, 1'b0);
        trig = 4'b0000; fast = 1'b0;

        // clear-on-read on ch1 at 7
        trig = 4'b0010;
        repeat (7) step();
        drv(1'b1, 1'b0, 2'd1, 1'b1);
        step();
        chk("t3_clr_rd", 64'(bus.count_o), 64'd8);
        drv(1'b1, 1'b0, 2'd1, 1'b0);
        step();
        chk("t3_after", 64'(bus.count_o), 64'd1);
        drv(1'b1, 1'b1, 2'd0, 1'b0);
        step();
        chk("t3_msb", 64'(bus.count_o), 64'd0);
        drv(1'b0, 1'b0, 2'd0, 1'b0);
        trig = 4'b0000;
        step();

        // illegal next-beat requests
        drv(1'b1, 1'b1, 2'd0, 1'b0);
        step();
        chk("t4_ack", 64'(bus.ack_o), 64'd1);
        chk("t4_err", 64'(bus.err_o), 64'd1);
        chk("t4_cnt", 64'(bus.count_o), 64'd0);
        drv(1'b1, 1'b0, 2'd3, 1'b0);
        step();
        chk("t4_start_err", 64'(bus.err_o), 64'd0);
        drv(1'b1, 1'b1, 2'd0, 1'b0);
        step();
        chk("t4_beat1_err", 64'(bus.err_o), 64'd0);
        step();
        chk("t4_beat2_err", 64'(bus.err_o), 64'd1);
        chk("t4_beat2_cnt", 64'(bus.count_o), 64'd0);
        drv(1'b0, 1'b0, 2'd0, 1'b0);

        // restart: ch3 loaded with 5e9, ch0 holds 12
        trig = 4'b1000; fast = 1'b1;
        repeat (5000) step();
        trig = 4'b0000; fast = 1'b0;
        drv(1'b1, 1'b0, 2'd0, 1'b0);
        step();
        chk("t6_ch0", 64'(bus.count_o), 64'd12);
        drv(1'b1, 1'b0, 2'd3, 1'b0);
        step();
        chk("t6_ch3_lsb", 64'(bus.count_o), 64'h2A05_F200);
        drv(1'b1, 1'b1, 2'd0, 1'b0);
        step();
        chk("t6_ch3_msb", 64'(bus.count_o), 64'd1);
        drv(1'b1, 1'b0, 2'd0, 1'b0);
        step();
        drv(1'b0, 1'b0, 2'd0, 1'b0);
        reset = 1'b1;
        #1;
        chk("t6_async_ack", 64'(bus.ack_o), 64'd0);
        chk("t6_async_cnt", 64'(bus.count_o), 64'd0);
        step();
        reset = 1'b0;
        step();
        drv(1'b1, 1'b1, 2'd0, 1'b0);
        step();
        chk("t6_post_ack", 64'(bus.ack_o), 64'd1);
        chk("t6_post_err", 64'(bus.err_o), 64'd1);
        drv(1'b1, 1'b0, 2'd3, 1'b0);
        step();
        chk("t6_ch3_clr", 64'(bus.count_o), 64'd0);
        drv(1'b0, 1'b0, 2'd0, 1'b0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
